axi_read_responder: RTL and testbench

// - AXI4 read-channel responder (slave) serving incremental read bursts from a single-port SRAM with one-cycle read latency.
// - Counterpart to the framebuffer DMA master: it acts as the memory side that answers AR requests with R beats.
// - Used as the framebuffer/memory model in FPGA bring-up and as the responder in DMA master testbenches.
// - Sits between the AXI interconnect and an SRAM macro. Write channels are unsupported and tied off.

---
 rtl/axi_read_responder_if.sv | 24 ++
 rtl/axi_read_responder.sv | 135 +++++++++++++
 tb/tb_axi_read_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_responder_if.sv
// AXI4 bus bundle shared by the read responder and its masters.
// Only the read channels carry traffic; the write-channel readies are tied off by the responder.
interface axi_interface;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic        awready;
   logic        wready;
   logic        bvalid;

   modport slave (
      input  araddr, arlen, arvalid, rready,
      output arready, rdata, rvalid, awready, wready, bvalid
   );

   modport master (
      output araddr, arlen, arvalid, rready,
      input  arready, rdata, rvalid, awready, wready, bvalid
   );
endinterface

// File: rtl/axi_read_responder.sv
// AXI4 read-only responder: serves incrementing bursts from a one-cycle-latency SRAM
// through a 2-entry output FIFO, one outstanding burst at a time.
module axi_read_responder #(
   parameter logic [31:0] BASE_ADDR      = 32'h10000000,
   parameter int          MEM_ADDR_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   axi_interface.slave               axi_bus,
   output logic                      mem_read_en,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]               mem_read_data
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                    state;
   state_t                    next_state;
   logic [MEM_ADDR_WIDTH-1:0] word_addr;
   logic [8:0]                total;
   logic [8:0]                issued;
   logic [8:0]                beat;
   logic                      in_flight;
   logic [31:0]               fifo_mem [2];
   logic                      wr_ptr;
   logic                      rd_ptr;
   logic [1:0]                fifo_count;
   logic                      arready_int;
   logic                      ar_hs;
   logic                      r_hs;
   logic                      issue;
   logic                      last_beat;
   logic [2:0]                occupancy;

   assign axi_bus.arready = arready_int;
   assign axi_bus.rvalid  = (fifo_count != 2'd0);
   assign axi_bus.rdata   = fifo_mem[rd_ptr];
   assign axi_bus.awready = 1'b0;
   assign axi_bus.wready  = 1'b0;
   assign axi_bus.bvalid  = 1'b0;

   assign mem_read_en = issue;
   assign mem_addr    = word_addr;

   // Occupancy the FIFO will have once this cycle's in-flight read lands and any dequeue retires.
   assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, r_hs};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      arready_int = 1'b0;
      issue       = 1'b0;
      last_beat   = 1'b0;
      r_hs        = axi_bus.rvalid && axi_bus.rready;
      ar_hs       = 1'b0;
      case (state)
         IDLE: begin
            arready_int = 1'b1;
            ar_hs       = axi_bus.arvalid;
            if (axi_bus.arvalid) begin
               next_state = BURST;
            end
         end
         BURST: begin
            issue     = (issued < total) && (occupancy < 3'd2);
            last_beat = r_hs && (beat == total - 9'd1);
            if (last_beat) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Burst bookkeeping; clearing in_flight on reset discards a read the SRAM is still returning.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_addr  <= '0;
         total      <= 9'd0;
         issued     <= 9'd0;
         beat       <= 9'd0;
         in_flight  <= 1'b0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (ar_hs) begin
            word_addr <= MEM_ADDR_WIDTH'((axi_bus.araddr - BASE_ADDR) >> 2);
            total     <= {1'b0, axi_bus.arlen} + 9'd1;
            issued    <= 9'd0;
            beat      <= 9'd0;
         end else begin
            if (issue) begin
               word_addr <= word_addr + 1'b1;
               issued    <= issued + 9'd1;
            end
            if (r_hs) begin
               beat <= beat + 9'd1;
            end
         end
         in_flight <= issue;
         if (in_flight) begin
            wr_ptr <= ~wr_ptr;
         end
         if (r_hs) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({in_flight, r_hs})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (in_flight) begin
         fifo_mem[wr_ptr] <= mem_read_data;
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(in_flight && fifo_count == 2'd2 && !r_hs));

   a_aligned_ar : assert property (@(posedge clk) disable iff (reset)
      ar_hs |-> (axi_bus.araddr[1:0] == 2'b00));

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: SRAM word k holds k, R beats are checked
// against a scoreboard of expected words filled whenever an AR request is driven.
module tb_axi_read_responder;

   localparam logic [31:0] BASE_ADDR      = 32'h10000000;
   localparam int          MEM_ADDR_WIDTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_en;
   logic [15:0] mem_addr;
   logic [31:0] mem_read_data;
   logic [31:0] sram [0:65535];

   logic [31:0] expected_q [$];
   logic [15:0] addr_log [$];
   int          check_count = 0;
   int          pass_count  = 0;
   int          fail_count  = 0;
   int          beat_count  = 0;
   logic        hold_valid  = 1'b0;
   logic [31:0] hold_data   = 32'h0;

   axi_interface axi_bus();

   axi_read_responder #(
      .BASE_ADDR      (BASE_ADDR),
      .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .axi_bus       (axi_bus),
      .mem_read_en   (mem_read_en),
      .mem_addr      (mem_addr),
      .mem_read_data (mem_read_data)
   );

   always #5 clk = ~clk;

   // One-cycle-latency SRAM model.
   always @(posedge clk) begin
      if (mem_read_en) begin
         mem_read_data <= sram[mem_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Mid-cycle monitor: a beat seen here with rready high completes on the next rising edge.
   always @(negedge clk) begin
      if (reset) begin
         hold_valid = 1'b0;
      end else begin
         if (hold_valid) begin
            checkOutput("r_hold_valid", 32'(axi_bus.rvalid), 32'd1);
            checkOutput("r_hold_data", axi_bus.rdata, hold_data);
         end
         if (mem_read_en) begin
            addr_log.push_back(mem_addr);
         end
         if (axi_bus.rvalid && axi_bus.rready) begin
            checkOutput("sb_nonempty", 32'(expected_q.size() != 0), 32'd1);
            if (expected_q.size() != 0) begin
               checkOutput("r_data", axi_bus.rdata, expected_q.pop_front());
            end
            beat_count++;
         end
         hold_valid = axi_bus.rvalid && !axi_bus.rready;
         hold_data  = axi_bus.rdata;
      end
   end

   task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len);
      logic [15:0] k;
      int          n;
      k = 16'((addr - BASE_ADDR) >> 2);
      for (int i = 0; i <= int'(len); i++) begin
         expected_q.push_back({16'h0000, k});
         k = k + 16'd1;
      end
      axi_bus.araddr  = addr;
      axi_bus.arlen   = len;
      axi_bus.arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!axi_bus.arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ar_accept", 32'(axi_bus.arready), 32'd1);
      @(posedge clk);
      #1 axi_bus.arvalid = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (expected_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      checkOutput("drain", 32'(expected_q.size()), 32'd0);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [15:0] wrap_exp [4];
      logic [31:0] obs;
      int          base;
      int          n;

      wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      for (int k = 0; k < 65536; k++) begin
         sram[k] = 32'(k);
      end
      void'($urandom(32'd20240611));

      reset           = 1'b1;
      axi_bus.araddr  = 32'h0;
      axi_bus.arlen   = 8'h0;
      axi_bus.arvalid = 1'b0;
      axi_bus.rready  = 1'b1;

      @(posedge clk); #1;
      checkOutput("reset_arready", 32'(axi_bus.arready), 32'd1);
      checkOutput("reset_rvalid", 32'(axi_bus.rvalid), 32'd0);
      checkOutput("reset_mem_read_en", 32'(mem_read_en), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("idle_arready", 32'(axi_bus.arready), 32'd1);
         checkOutput("idle_rvalid", 32'(axi_bus.rvalid), 32'd0);
         checkOutput("idle_mem_read_en", 32'(mem_read_en), 32'd0);
      end

      $display("[TB] single-beat read at 0x10000010");
      applyStimulus(32'h10000010, 8'd0);
      checkOutput("lat_t0_rvalid", 32'(axi_bus.rvalid), 32'd0);
      checkOutput("lat_t0_mem_read_en", 32'(mem_read_en), 32'd1);
      checkOutput("lat_t0_mem_addr", 32'(mem_addr), 32'd4);
      checkOutput("lat_t0_arready", 32'(axi_bus.arready), 32'd0);
      @(posedge clk); #1;
      checkOutput("lat_t1_rvalid", 32'(axi_bus.rvalid), 32'd0);
      checkOutput("lat_t1_mem_read_en", 32'(mem_read_en), 32'd0);
      @(posedge clk); #1;
      checkOutput("lat_t2_rvalid", 32'(axi_bus.rvalid), 32'd1);
      checkOutput("lat_t2_rdata", axi_bus.rdata, 32'd4);
      checkOutput("lat_t2_arready", 32'(axi_bus.arready), 32'd0);
      @(posedge clk); #1;
      checkOutput("single_done_rvalid", 32'(axi_bus.rvalid), 32'd0);
      checkOutput("single_done_arready", 32'(axi_bus.arready), 32'd1);
      checkOutput("single_drained", 32'(expected_q.size()), 32'd0);

      $display("[TB] 64-beat burst, rready held high");
      applyStimulus(BASE_ADDR, 8'd63);
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 64; i++) begin
         checkOutput("burst_rvalid", 32'(axi_bus.rvalid), 32'd1);
         checkOutput("burst_arready", 32'(axi_bus.arready), 32'd0);
         @(posedge clk); #1;
      end
      checkOutput("burst_end_rvalid", 32'(axi_bus.rvalid), 32'd0);
      checkOutput("burst_end_arready", 32'(axi_bus.arready), 32'd1);
      checkOutput("burst_drained", 32'(expected_q.size()), 32'd0);

      $display("[TB] 64-beat burst, rready toggled pseudo-randomly");
      base = beat_count;
      applyStimulus(BASE_ADDR, 8'd63);
      n = 0;
      while (expected_q.size() != 0 && n < 2000) begin
         axi_bus.rready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      axi_bus.rready = 1'b1;
      checkOutput("random_drained", 32'(expected_q.size()), 32'd0);
      checkOutput("random_beats", 32'(beat_count - base), 32'd64);
      checkOutput("random_end_arready", 32'(axi_bus.arready), 32'd1);

      $display("[TB] wrapping burst near top of window");
      addr_log.delete();
      applyStimulus(BASE_ADDR + 32'(4 * (65536 - 2)), 8'd3);
      waitDrain(200);
      checkOutput("wrap_issue_count", 32'(addr_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         obs = (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hFFFFFFFF;
         checkOutput("wrap_mem_addr", obs, 32'(wrap_exp[i]));
      end

      $display("[TB] reset in the middle of a 64-beat burst");
      base = beat_count;
      applyStimulus(BASE_ADDR, 8'd63);
      n = 0;
      while ((beat_count - base) < 10 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("midreset_beats_before", 32'(beat_count - base), 32'd10);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("midreset_rvalid", 32'(axi_bus.rvalid), 32'd0);
      checkOutput("midreset_arready", 32'(axi_bus.arready), 32'd1);
      checkOutput("midreset_mem_read_en", 32'(mem_read_en), 32'd0);
      expected_q.delete();
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("postreset_rvalid", 32'(axi_bus.rvalid), 32'd0);
      base = beat_count;
      applyStimulus(BASE_ADDR, 8'd1);
      waitDrain(100);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("postreset_beats", 32'(beat_count - base), 32'd2);
      checkOutput("postreset_idle_rvalid", 32'(axi_bus.rvalid), 32'd0);
      checkOutput("postreset_idle_arready", 32'(axi_bus.arready), 32'd1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
